// File: rtl/stack_engine.sv
// Stack pointer with stack-page address generation and multi-byte push/pop burst sequencing.
// Optional sticky overflow/underflow guard enabled by defining STACK_GUARD_EN.
module stack_engine #(
  parameter int                SP_W      = 8,
  parameter int                PAGE_W    = 8,
  parameter logic [PAGE_W-1:0] PAGE      = 8'h01,
  parameter logic [SP_W-1:0]   SP_RESET  = 8'hFF,
  parameter int                MAX_BURST = 3,
  parameter int                CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SP_W-1:0]        data_in,
  input  logic                   load,
  input  logic                   push_req,
  input  logic                   pop_req,
  input  logic [CW-1:0]          len,
  input  logic                   err_clr,
  output logic                   busy,
  output logic [PAGE_W+SP_W-1:0] mem_addr,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic [CW-1:0]          beat,
  output logic                   done,
  output logic [SP_W-1:0]        sp_out,
  output logic                   overflow,
  output logic                   underflow
);

  typedef enum logic [1:0] {IDLE, PUSH, POP} state_t;

  state_t          state_q, state_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [SP_W-1:0] addr_off;
  logic [CW-1:0]   len_clamped;

  assign len_clamped = (len > CW'(MAX_BURST)) ? CW'(MAX_BURST) : len;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    len_d    = len_q;
    beat_d   = beat_q;
    addr_off = sp_q;
    busy     = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          sp_d = data_in;
        end else if (push_req && len != '0) begin
          len_d   = len_clamped;
          beat_d  = '0;
          state_d = PUSH;
        end else if (pop_req && len != '0) begin
          len_d   = len_clamped;
          beat_d  = '0;
          state_d = POP;
        end
      end
      PUSH, POP: begin
        busy = 1'b1;
        if (state_q == PUSH) begin
          mem_we = 1'b1;
          sp_d   = sp_q - SP_W'(1);
        end else begin
          // Pre-increment: the pop reads the slot above the current SP.
          addr_off = sp_q + SP_W'(1);
          mem_re   = 1'b1;
          sp_d     = sp_q + SP_W'(1);
        end
        done = (beat_q == len_q - CW'(1));
        if (done) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sp_q    <= SP_RESET;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  assign mem_addr = {PAGE, addr_off};
  assign beat     = beat_q;
  assign sp_out   = sp_q;

`ifdef STACK_GUARD_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A flag being set in the same cycle as err_clr wins over the clear.
  always_comb begin
    ovf_d = err_clr ? 1'b0 : ovf_q;
    unf_d = err_clr ? 1'b0 : unf_q;
    if (mem_we && sp_q == '0) ovf_d = 1'b1;
    if (mem_re && sp_q == '1) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_stack_engine.sv
// Directed self-checking bench for stack_engine: reset, bursts, wrap, priority and mid-burst reset.
module tb_stack_engine;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    data_in;
  logic          load, push_req, pop_req, err_clr;
  logic [CW-1:0] len;
  logic          busy, mem_we, mem_re, done, overflow, underflow;
  logic [15:0]   mem_addr;
  logic [CW-1:0] beat;
  logic [7:0]    sp_out;

  int tests = 0;
  int fails = 0;

`ifdef STACK_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  stack_engine dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .push_req(push_req), .pop_req(pop_req), .len(len), .err_clr(err_clr),
    .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .beat(beat), .done(done), .sp_out(sp_out),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one beat: strobe kind, address, beat index and done.
  task automatic check_beat(input string tag, input logic we, input logic re,
                            input logic [15:0] addr, input logic [CW-1:0] b, input logic d);
    check({tag, " busy"}, 32'(busy), 32'(1));
    check({tag, " we"},   32'(mem_we), 32'(we));
    check({tag, " re"},   32'(mem_re), 32'(re));
    check({tag, " addr"}, 32'(mem_addr), 32'(addr));
    check({tag, " beat"}, 32'(beat), 32'(b));
    check({tag, " done"}, 32'(done), 32'(d));
  endtask

  task automatic check_idle(input string tag, input logic [7:0] sp);
    check({tag, " busy"}, 32'(busy), 32'(0));
    check({tag, " strobes"}, 32'({mem_we, mem_re, done}), 32'(0));
    check({tag, " sp"}, 32'(sp_out), 32'(sp));
    check({tag, " addr"}, 32'(mem_addr), 32'({8'h01, sp}));
    check({tag, " beat"}, 32'(beat), 32'(0));
  endtask

  initial begin
    reset = 1'b0; data_in = '0; load = 0; push_req = 0; pop_req = 0; len = '0; err_clr = 0;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check_idle("reset", 8'hFF);
    check("reset flags", 32'({overflow, underflow}), 32'(0));

    // Push 3 from FF.
    tick();
    push_req = 1; len = 2'd3;
    tick();
    push_req = 0; len = '0;
    check_beat("push b0", 1, 0, 16'h01FF, 2'd0, 0);
    tick();
    check_beat("push b1", 1, 0, 16'h01FE, 2'd1, 0);
    tick();
    check_beat("push b2", 1, 0, 16'h01FD, 2'd2, 1);
    tick();
    check_idle("push end", 8'hFC);

    // Pop 2 from FC.
    pop_req = 1; len = 2'd2;
    tick();
    pop_req = 0; len = '0;
    check_beat("pop b0", 0, 1, 16'h01FD, 2'd0, 0);
    tick();
    check_beat("pop b1", 0, 1, 16'h01FE, 2'd1, 1);
    tick();
    check_idle("pop end", 8'hFE);

    // len == 0 is ignored.
    push_req = 1; len = '0;
    tick();
    push_req = 0;
    check_idle("len0", 8'hFE);

    // Wrap on push from 00.
    load = 1; data_in = 8'h00;
    tick();
    load = 0;
    check_idle("load00", 8'h00);
    push_req = 1; len = 2'd2;
    tick();
    push_req = 0; len = '0;
    check_beat("wrap b0", 1, 0, 16'h0100, 2'd0, 0);
    tick();
    check_beat("wrap b1", 1, 0, 16'h01FF, 2'd1, 1);
    check("ovf set", 32'(overflow), 32'(GUARD));
    tick();
    check_idle("wrap end", 8'hFE);
    check("ovf sticky", 32'(overflow), 32'(GUARD));
    err_clr = 1;
    tick();
    err_clr = 0;
    check("ovf clr", 32'(overflow), 32'(0));

    // Wrap on pop from FF.
    load = 1; data_in = 8'hFF;
    tick();
    load = 0;
    pop_req = 1; len = 2'd1;
    tick();
    pop_req = 0; len = '0;
    check_beat("uwrap b0", 0, 1, 16'h0100, 2'd0, 1);
    tick();
    check_idle("uwrap end", 8'h00);
    check("unf set", 32'(underflow), 32'(GUARD));
    check("unf no ovf", 32'(overflow), 32'(0));
    err_clr = 1;
    tick();
    err_clr = 0;
    check("unf clr", 32'(underflow), 32'(0));

    // load beats push_req.
    load = 1; data_in = 8'h40; push_req = 1; len = 2'd2;
    tick();
    load = 0; push_req = 0; len = '0;
    check_idle("ld>push", 8'h40);

    // push beats pop.
    push_req = 1; pop_req = 1; len = 2'd1;
    tick();
    push_req = 0; pop_req = 0; len = '0;
    check_beat("push>pop", 1, 0, 16'h0140, 2'd0, 1);
    tick();
    check_idle("push>pop end", 8'h3F);

    // load ignored during burst.
    push_req = 1; len = 2'd3;
    tick();
    push_req = 0; len = '0;
    load = 1; data_in = 8'h99;
    check_beat("busyld b0", 1, 0, 16'h013F, 2'd0, 0);
    tick();
    check_beat("busyld b1", 1, 0, 16'h013E, 2'd1, 0);
    tick();
    load = 0;
    check_beat("busyld b2", 1, 0, 16'h013D, 2'd2, 1);
    tick();
    check_idle("busyld end", 8'h3C);

    // Reset during beat 1 of a 3-byte push.
    push_req = 1; len = 2'd3;
    tick();
    push_req = 0; len = '0;
    tick();
    check_beat("rst b1", 1, 0, 16'h013B, 2'd1, 0);
    reset = 1'b0;
    #1;
    check_idle("rst async", 8'hFF);
    #1;
    reset = 1'b1;
    tick();
    check_idle("rst after", 8'hFF);
    tick();
    check_idle("rst after2", 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
